// File: rtl/mbc_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// mbc_ctrl_pkg
// Shared definitions for the MBC fetch controller:
//   - state_t     : sequencer state encoding
//   - BUS_*       : common-bus source select codes
//   - IR_*        : instruction-word field positions (I bit, opcode)
//   - bus_sel_of  : bus source driven in a given state
// ----------------------------------------------------------------------------
package mbc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_INIT   = 3'd1,
        ST_T0     = 3'd2,
        ST_T1     = 3'd3,
        ST_T2     = 3'd4,
        ST_EXEC   = 3'd5,
        ST_HALTED = 3'd6
    } state_t;

    localparam logic [2:0] BUS_NONE = 3'd0;
    localparam logic [2:0] BUS_PC   = 3'd2;
    localparam logic [2:0] BUS_IR   = 3'd5;
    localparam logic [2:0] BUS_MEM  = 3'd7;

    localparam int IR_I_BIT  = 15;
    localparam int IR_OP_MSB = 14;
    localparam int IR_OP_LSB = 12;

    // Only the fetch/decode steps place anything on the bus.
    function automatic logic [2:0] bus_sel_of(input state_t s);
        case (s)
            ST_T0:   return BUS_PC;
            ST_T1:   return BUS_MEM;
            ST_T2:   return BUS_IR;
            default: return BUS_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mbc_seq_counter.sv
// ----------------------------------------------------------------------------
// mbc_seq_counter
// T-step sequence counter. Clear has priority over increment; the count
// saturates at all-ones instead of wrapping.
// Ports:
//   i_clk    : clock
//   i_rst    : asynchronous active-high reset (count -> 0)
//   i_clear  : synchronous clear to 0
//   i_inc    : increment by one (held at all-ones once reached)
//   o_count  : current count
// ----------------------------------------------------------------------------
module mbc_seq_counter #(
    parameter int SC_WIDTH = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_clear,
    input  logic                i_inc,
    output logic [SC_WIDTH-1:0] o_count
);

    logic [SC_WIDTH-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {SC_WIDTH{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/mbc_fetch_controller.sv
// ----------------------------------------------------------------------------
// mbc_fetch_controller
// Timing/control sequencer for the MBC register datapath: runs the
// fetch (T0/T1), decode (T2) and execute-handoff (EXEC) phases and drives the
// PC/AR/IR strobes and bus source select.
// Ports:
//   CLOCK, RESET            : clock, asynchronous active-high reset
//   START                   : begin from IDLE / resume from HALTED
//   HALT_REQ                : halt at the next instruction boundary
//   MEM_READY               : memory read data valid (sampled in T1)
//   EXEC_DONE               : execute unit finished (sampled in EXEC)
//   IR_DATA                 : IR register contents
//   PC_CLEAR, PC_INCREMENT  : PC strobes
//   AR_WRITE_ENABLE         : AR load from bus
//   IR_WRITE_ENABLE         : IR load from bus
//   MEM_READ                : memory read request
//   BUS_SEL                 : bus source (0 none, 2 PC, 5 IR, 7 MEM)
//   SC                      : sequence counter
//   OPCODE, INDIRECT        : decoded fields of the current instruction
//   EXEC_START              : one-cycle pulse on the first EXEC cycle
//   BUSY                    : high outside IDLE and HALTED
// ----------------------------------------------------------------------------
module mbc_fetch_controller
    import mbc_ctrl_pkg::*;
#(
    parameter int IR_WIDTH = 16,
    parameter int SC_WIDTH = 4
) (
    input  logic                CLOCK,
    input  logic                RESET,
    input  logic                START,
    input  logic                HALT_REQ,
    input  logic                MEM_READY,
    input  logic                EXEC_DONE,
    input  logic [IR_WIDTH-1:0] IR_DATA,
    output logic                PC_CLEAR,
    output logic                PC_INCREMENT,
    output logic                AR_WRITE_ENABLE,
    output logic                IR_WRITE_ENABLE,
    output logic                MEM_READ,
    output logic [2:0]          BUS_SEL,
    output logic [SC_WIDTH-1:0] SC,
    output logic [2:0]          OPCODE,
    output logic                INDIRECT,
    output logic                EXEC_START,
    output logic                BUSY
);

    state_t              r_state;
    state_t              w_state_next;
    logic                r_halt;
    logic                r_pc_clear;
    logic                r_ar_we;
    logic                r_mem_read;
    logic [2:0]          r_bus_sel;
    logic                r_exec_start;
    logic                r_busy;
    logic [2:0]          r_opcode;
    logic                r_indirect;
    logic                w_mem_take;
    logic                w_busy_now;
    logic                w_sc_clear;
    logic                w_sc_inc;
    logic [SC_WIDTH-1:0] w_sc;
    logic                w_unused_ir;

    // Only the I bit and opcode are decoded here; the address field belongs
    // to the datapath.
    assign w_unused_ir = ^IR_DATA;

    assign w_mem_take = (r_state == ST_T1) && MEM_READY;
    assign w_busy_now = (r_state != ST_IDLE) && (r_state != ST_HALTED);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (START) w_state_next = ST_INIT;
            ST_INIT:   w_state_next = ST_T0;
            ST_T0:     w_state_next = ST_T1;
            ST_T1:     if (MEM_READY) w_state_next = ST_T2;
            ST_T2:     w_state_next = ST_EXEC;
            // A HALT_REQ arriving with EXEC_DONE still halts at this boundary.
            ST_EXEC:   if (EXEC_DONE) w_state_next = (r_halt || HALT_REQ) ? ST_HALTED : ST_T0;
            ST_HALTED: if (START) w_state_next = ST_T0;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // SC is zero in every non-fetch/execute state and at T0; it advances on
    // each step transition and on every cycle spent in EXEC.
    assign w_sc_clear = (w_state_next == ST_T0)   || (w_state_next == ST_IDLE) ||
                        (w_state_next == ST_INIT) || (w_state_next == ST_HALTED);
    assign w_sc_inc   = !w_sc_clear &&
                        ((w_state_next != r_state) || (r_state == ST_EXEC));

    mbc_seq_counter #(
        .SC_WIDTH (SC_WIDTH)
    ) u_seq_counter (
        .i_clk   (CLOCK),
        .i_rst   (RESET),
        .i_clear (w_sc_clear),
        .i_inc   (w_sc_inc),
        .o_count (w_sc)
    );

    // Moore strobes are registered from the next state so they line up with
    // the state they belong to.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_state      <= ST_IDLE;
            r_halt       <= 1'b0;
            r_pc_clear   <= 1'b0;
            r_ar_we      <= 1'b0;
            r_mem_read   <= 1'b0;
            r_bus_sel    <= BUS_NONE;
            r_exec_start <= 1'b0;
            r_busy       <= 1'b0;
            r_opcode     <= 3'd0;
            r_indirect   <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_pc_clear   <= (w_state_next == ST_INIT);
            r_ar_we      <= (w_state_next == ST_T0) || (w_state_next == ST_T2);
            r_mem_read   <= (w_state_next == ST_T1);
            r_bus_sel    <= bus_sel_of(w_state_next);
            r_exec_start <= (r_state == ST_T2);
            r_busy       <= (w_state_next != ST_IDLE) && (w_state_next != ST_HALTED);

            if (w_state_next == ST_HALTED) begin
                r_halt <= 1'b0;
            end else if (HALT_REQ && w_busy_now) begin
                r_halt <= 1'b1;
            end

            if (r_state == ST_T2) begin
                r_opcode   <= IR_DATA[IR_OP_MSB:IR_OP_LSB];
                r_indirect <= IR_DATA[IR_I_BIT];
            end
        end
    end

    // RESET gates every strobe combinationally so nothing leaks mid-cycle.
    assign PC_CLEAR        = r_pc_clear   & ~RESET;
    assign PC_INCREMENT    = w_mem_take   & ~RESET;
    assign IR_WRITE_ENABLE = w_mem_take   & ~RESET;
    assign AR_WRITE_ENABLE = r_ar_we      & ~RESET;
    assign MEM_READ        = r_mem_read   & ~RESET;
    assign BUS_SEL         = r_bus_sel    & {3{~RESET}};
    assign SC              = w_sc         & {SC_WIDTH{~RESET}};
    assign OPCODE          = r_opcode     & {3{~RESET}};
    assign INDIRECT        = r_indirect   & ~RESET;
    assign EXEC_START      = r_exec_start & ~RESET;
    assign BUSY            = r_busy       & ~RESET;

endmodule

// File: tb/tb_mbc_fetch_controller.sv
// ----------------------------------------------------------------------------
// tb_mbc_fetch_controller
// Directed walk through fetch/decode/execute, wait states, saturation, halt
// and asynchronous reset, followed by randomized stimulus. A behavioural
// model (mode + unbounded T-step count) predicts every output each cycle.
// ----------------------------------------------------------------------------
module tb_mbc_fetch_controller;

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic        START;
    logic        HALT_REQ;
    logic        MEM_READY;
    logic        EXEC_DONE;
    logic [15:0] IR_DATA;
    logic        PC_CLEAR;
    logic        PC_INCREMENT;
    logic        AR_WRITE_ENABLE;
    logic        IR_WRITE_ENABLE;
    logic        MEM_READ;
    logic [2:0]  BUS_SEL;
    logic [3:0]  SC;
    logic [2:0]  OPCODE;
    logic        INDIRECT;
    logic        EXEC_START;
    logic        BUSY;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    always #5 CLOCK = ~CLOCK;

    mbc_fetch_controller #(
        .IR_WIDTH (16),
        .SC_WIDTH (4)
    ) dut (
        .CLOCK           (CLOCK),
        .RESET           (RESET),
        .START           (START),
        .HALT_REQ        (HALT_REQ),
        .MEM_READY       (MEM_READY),
        .EXEC_DONE       (EXEC_DONE),
        .IR_DATA         (IR_DATA),
        .PC_CLEAR        (PC_CLEAR),
        .PC_INCREMENT    (PC_INCREMENT),
        .AR_WRITE_ENABLE (AR_WRITE_ENABLE),
        .IR_WRITE_ENABLE (IR_WRITE_ENABLE),
        .MEM_READ        (MEM_READ),
        .BUS_SEL         (BUS_SEL),
        .SC              (SC),
        .OPCODE          (OPCODE),
        .INDIRECT        (INDIRECT),
        .EXEC_START      (EXEC_START),
        .BUSY            (BUSY)
    );

    logic [17:0] act_vec;
    assign act_vec = {PC_CLEAR, PC_INCREMENT, AR_WRITE_ENABLE, IR_WRITE_ENABLE,
                      MEM_READ, BUS_SEL, SC, OPCODE, INDIRECT, EXEC_START, BUSY};

    // ---------------- behavioural model ----------------
    // m_mode: 0 idle, 1 init, 2 running, 3 halted.
    // m_t   : T-step count within an instruction (unbounded; 3+ is execute).
    int         m_mode = 0;
    int         m_t    = 0;
    bit         m_halt = 1'b0;
    logic [2:0] m_op   = 3'd0;
    logic       m_ind  = 1'b0;

    always @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            m_mode <= 0;
            m_t    <= 0;
            m_halt <= 1'b0;
            m_op   <= 3'd0;
            m_ind  <= 1'b0;
        end else begin
            case (m_mode)
                0: if (START) m_mode <= 1;
                1: begin
                    m_mode <= 2;
                    m_t    <= 0;
                    if (HALT_REQ) m_halt <= 1'b1;
                end
                2: begin
                    if (m_t >= 3 && EXEC_DONE) begin
                        if (m_halt || HALT_REQ) begin
                            m_mode <= 3;
                            m_halt <= 1'b0;
                        end else begin
                            m_t <= 0;
                        end
                    end else begin
                        if (HALT_REQ) m_halt <= 1'b1;
                        if (m_t == 1) begin
                            if (MEM_READY) m_t <= 2;
                        end else begin
                            if (m_t == 2) begin
                                m_op  <= IR_DATA[14:12];
                                m_ind <= IR_DATA[15];
                            end
                            m_t <= m_t + 1;
                        end
                    end
                end
                default: if (START) begin
                    m_mode <= 2;
                    m_t    <= 0;
                end
            endcase
        end
    end

    function automatic logic [17:0] expected_vec();
        logic       run;
        logic       pc_clr;
        logic       take;
        logic       ar_we;
        logic       mrd;
        logic [2:0] bus;
        logic [3:0] sc;
        logic       es;
        logic       busy;
        if (RESET) return 18'd0;
        run    = (m_mode == 2);
        pc_clr = (m_mode == 1);
        take   = run && (m_t == 1) && MEM_READY;
        ar_we  = run && (m_t == 0 || m_t == 2);
        mrd    = run && (m_t == 1);
        bus    = !run ? 3'd0 : (m_t == 0) ? 3'd2 : (m_t == 1) ? 3'd7 : (m_t == 2) ? 3'd5 : 3'd0;
        sc     = !run ? 4'd0 : (m_t > 15) ? 4'd15 : 4'(m_t);
        es     = run && (m_t == 3);
        busy   = (m_mode == 1) || run;
        return {pc_clr, take, ar_we, take, mrd, bus, sc, m_op, m_ind, es, busy};
    endfunction

    // One comparison per cycle, on the falling edge.
    always @(negedge CLOCK) begin
        if (cmp_en) begin
            logic [17:0] exp_v;
            exp_v = expected_vec();
            n_tests++;
            if (act_vec !== exp_v) begin
                n_fail++;
                $display("FAIL cycle_cmp @%0t: got %05h expected %05h (mode=%0d t=%0d)",
                         $time, act_vec, exp_v, m_mode, m_t);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic look();
        #3;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("[TB] %s = %0d", name, act);
        end
    endtask

    initial begin
        RESET     = 1'b1;
        START     = 1'b0;
        HALT_REQ  = 1'b0;
        MEM_READY = 1'b0;
        EXEC_DONE = 1'b0;
        IR_DATA   = 16'h0000;

        repeat (2) step();
        look();
        chk("reset_busy", BUSY, 0);
        chk("reset_sc", SC, 0);
        chk("reset_vec", act_vec, 0);

        step();
        RESET  = 1'b0;
        cmp_en = 1'b1;

        // First instruction with memory always ready.
        step();
        START     = 1'b1;
        MEM_READY = 1'b1;
        IR_DATA   = 16'hB123;
        step();
        START = 1'b0;
        look();
        chk("init_pc_clear", PC_CLEAR, 1);
        step(); look();
        chk("t0_bus", BUS_SEL, 2);
        chk("t0_sc", SC, 0);
        step(); look();
        chk("t1_bus", BUS_SEL, 7);
        chk("t1_ir_we", IR_WRITE_ENABLE, 1);
        chk("t1_pc_inc", PC_INCREMENT, 1);
        step(); look();
        chk("t2_bus", BUS_SEL, 5);
        chk("t2_sc", SC, 2);
        step();
        MEM_READY = 1'b0;
        look();
        chk("exec_start", EXEC_START, 1);
        chk("exec_sc", SC, 3);
        chk("opcode_b123", OPCODE, 3);
        chk("indirect_b123", INDIRECT, 1);

        // Long execute: SC saturates.
        repeat (20) step();
        look();
        chk("sc_saturated", SC, 15);
        chk("exec_start_once", EXEC_START, 0);
        step();
        EXEC_DONE = 1'b1;
        step();
        EXEC_DONE = 1'b0;
        look();
        chk("back_t0_sc", SC, 0);
        chk("back_t0_bus", BUS_SEL, 2);
        chk("hold_opcode", OPCODE, 3);

        // Three wait cycles in T1, then data arrives with a halt request.
        step(); look();
        chk("t1_wait_mem_read", MEM_READ, 1);
        chk("t1_wait_sc", SC, 1);
        chk("t1_wait_ir_we", IR_WRITE_ENABLE, 0);
        step();
        step();
        step();
        MEM_READY = 1'b1;
        IR_DATA   = 16'h4ABC;
        HALT_REQ  = 1'b1;
        look();
        chk("t1_ready_ir_we", IR_WRITE_ENABLE, 1);
        chk("t1_ready_pc_inc", PC_INCREMENT, 1);
        chk("hold_indirect", INDIRECT, 1);
        step();
        MEM_READY = 1'b0;
        HALT_REQ  = 1'b0;
        step();
        EXEC_DONE = 1'b1;
        look();
        chk("exec_start2", EXEC_START, 1);
        chk("opcode_4abc", OPCODE, 4);
        chk("indirect_4abc", INDIRECT, 0);
        step();
        EXEC_DONE = 1'b0;
        look();
        chk("halted_busy", BUSY, 0);
        chk("halted_sc", SC, 0);

        // Resume from HALTED goes straight to T0.
        step();
        step();
        START = 1'b1;
        step();
        START = 1'b0;
        look();
        chk("resume_pc_clear", PC_CLEAR, 0);
        chk("resume_bus", BUS_SEL, 2);
        chk("resume_busy", BUSY, 1);

        // Asynchronous reset in the middle of a T1 cycle.
        step();
        #2;
        RESET = 1'b1;
        #1;
        chk("async_reset_vec", act_vec, 0);
        step();
        RESET = 1'b0;
        look();
        chk("post_reset_busy", BUSY, 0);
        repeat (3) step();
        look();
        chk("idle_needs_start", BUSY, 0);
        step();
        START = 1'b1;
        step();
        START = 1'b0;
        look();
        chk("restart_pc_clear", PC_CLEAR, 1);

        // Randomized stimulus against the model.
        for (int i = 0; i < 3000; i++) begin
            step();
            RESET     = ($urandom_range(0, 299) == 0);
            START     = ($urandom_range(0, 7) == 0);
            HALT_REQ  = ($urandom_range(0, 15) == 0);
            MEM_READY = ($urandom_range(0, 1) == 1);
            EXEC_DONE = ($urandom_range(0, 3) == 0);
            IR_DATA   = 16'($urandom);
        end
        step();
        RESET = 1'b0;
        step();
        cmp_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
